// File: rtl/design_20_pkg.sv
// design_20_pkg
// Shared definitions for the design_20 registered adder.
//   DESIGN_20_W        default operand/result width
//   design_20_word_t   data word at the default width
package design_20_pkg;

    localparam int DESIGN_20_W = 8;

    typedef logic [DESIGN_20_W-1:0] design_20_word_t;

endpackage : design_20_pkg

// File: rtl/design_20_adder.sv
// design_20_adder
// Combinational W-bit wrap-around adder. The carry-out is discarded.
// Ports:
//   a    in  W  operand A
//   b    in  W  operand B
//   sum  out W  (a + b) mod 2^W
module design_20_adder
    import design_20_pkg::*;
#(
    parameter int W = DESIGN_20_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // A same-width add truncates the carry.
    assign sum = a + b;

endmodule : design_20_adder

// File: rtl/design_20.sv
// design_20
// Single pipeline stage: on a start edge, the wrapped sum of a and b is
// registered onto y and valid is raised for exactly one clock. Back-to-back
// starts give one result per clock. There is no backpressure.
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  asynchronous active-high reset
//   start  in  1  capture request
//   a      in  W  operand A
//   b      in  W  operand B
//   y      out W  registered sum, meaningful only while valid=1
//   valid  out 1  result-valid strobe
module design_20
    import design_20_pkg::*;
#(
    parameter int W = DESIGN_20_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         valid
);

    logic [W-1:0] sum;

    design_20_adder #(.W(W)) u_adder (
        .a   (a),
        .b   (b),
        .sum (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            y     <= '0;
        end else begin
            valid <= start;
            // y holds when idle so X on a/b cannot reach it.
            if (start) begin
                y <= sum;
            end
        end
    end

endmodule : design_20

// File: tb/tb_design_20.sv
// tb_design_20
// Self-checking bench for design_20 at the default width.
module tb_design_20;
    import design_20_pkg::*;

    localparam int W   = DESIGN_20_W;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;

    int vectors;
    int miscompares;

    // Reference model state: what the outputs should show after each edge.
    int unsigned exp_y;
    bit          exp_valid;

    design_20 #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_valid});
        check_eq({tag, ".y"}, {{(32-W){1'b0}}, y}, exp_y);
    endtask

    // One clock: update the model with the rule for the inputs present at
    // the edge, then sample the DUT 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst === 1'b1) begin
            exp_valid = 1'b0;
            exp_y     = 0;
        end else begin
            exp_valid = (start === 1'b1);
            if (start === 1'b1) begin
                exp_y = (int'(a) + int'(b)) % MOD;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic s, input int unsigned va, input int unsigned vb);
        start = s;
        a     = W'(va);
        b     = W'(vb);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_valid   = 1'b0;
        exp_y       = 0;

        // Reset held with start high: everything stays zero.
        rst = 1'b1;
        drive(1'b1, 'h12, 'h34);
        #1;
        check_outputs("reset_async");
        for (int i = 0; i < 3; i++) cycle("reset_hold");

        // Release away from the edge with start low: no valid afterwards.
        rst = 1'b0;
        drive(1'b0, 'h12, 'h34);
        cycle("post_release");

        // Single transaction and hold.
        drive(1'b1, 'h05, 'h03);
        cycle("single");
        check_eq("single_sum", {24'd0, y}, 32'h08);
        drive(1'b0, 'h00, 'h00);
        cycle("single_hold");
        check_eq("single_hold_y", {24'd0, y}, 32'h08);

        // X operands while idle must not disturb y.
        start = 1'b0;
        a     = 'x;
        b     = 'x;
        cycle("x_idle");

        // Overflow wrap cases.
        drive(1'b1, 'hFF, 'h01);
        cycle("wrap_ff_01");
        check_eq("wrap_ff_01_const", {24'd0, y}, 32'h00);
        drive(1'b1, 'hFF, 'hFF);
        cycle("wrap_ff_ff");
        check_eq("wrap_ff_ff_const", {24'd0, y}, 32'hFE);
        drive(1'b0, 0, 0);
        cycle("wrap_idle");

        // Back-to-back starts.
        drive(1'b1, 1, 2);
        cycle("b2b_0");
        drive(1'b1, 10, 20);
        cycle("b2b_1");
        drive(1'b1, 'h80, 'h80);
        cycle("b2b_2");
        check_eq("b2b_2_const", {24'd0, y}, 32'h00);
        drive(1'b0, 0, 0);
        cycle("b2b_end");

        // Reset in the cycle after a start: the result is dropped at once.
        drive(1'b1, 'h40, 'h01);
        cycle("mid_start");
        drive(1'b0, 0, 0);
        #2;
        rst = 1'b1;
        exp_valid = 1'b0;
        exp_y     = 0;
        #1;
        check_outputs("mid_reset_async");
        cycle("mid_reset_hold");
        #1;
        rst = 1'b0;
        drive(1'b1, 2, 2);
        cycle("mid_fresh");
        check_eq("mid_fresh_const", {24'd0, y}, 32'h04);
        drive(1'b0, 0, 0);
        cycle("mid_fresh_idle");

        // Random soak: single starts separated by two idle cycles.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
            cycle("soak_result");
            drive(1'b0, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
            cycle("soak_idle0");
            cycle("soak_idle1");
        end

        // Random burst with random start pattern.
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
            cycle("burst");
        end
        drive(1'b0, 0, 0);
        cycle("burst_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_design_20

// File: doc/design_20.md
Name: design_20

Overview:
- Single-cycle-latency registered adder with a start/valid handshake.
- On a `start` pulse, `a` and `b` are sampled and summed (modulo 2^W).
- The result is presented on `y` with `valid` asserted exactly one clock later.
- Used as a small datapath leaf; no backpressure.

Parameters:
- W, 8, operand and result width in bits (W >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- start  input  1  request; a and b are sampled on a clock edge where start=1.
- a  input  W  operand A.
- b  input  W  operand B.
- y  output  W  registered sum.
- valid  output  1  result-valid strobe.

Behaviour:
- Reset (rst=1, asynchronous assert, release synchronous to clk):
  - valid=0 and y=0 immediately.
  - Both remain 0 for every edge while rst=1.
  - start is ignored while rst=1.
- Latency: a start sampled at edge N gives valid=1 from edge N+1 until edge N+2.
  - y at that time = (a + b) mod 2^W, using the a/b values sampled at edge N.
- valid is registered directly from start: valid(next) = start. So:
  - Single-cycle start gives a single-cycle valid pulse.
  - Back-to-back starts give valid held high, with y updating every cycle to the sum of the previous cycle's operands.
  - Full throughput, one result per clock.
- y update rule:
  - y loads (a + b) mod 2^W only on edges where start=1.
  - Otherwise y holds its last value, including while valid=0.
  - y is meaningful only when valid=1.
- Arithmetic:
  - Unsigned W-bit addition; carry-out discarded (wrap-around).
  - Example W=8: 0xFF + 0x01 → 0x00; 0x80 + 0x80 → 0x00; 0xFF + 0xFF → 0xFE.
- No state machine beyond the two registers (valid flag, y register).
  - Implementation is a pure register pipeline stage.
- Reset mid-operation:
  - If rst asserts on the cycle after a start, valid is forced to 0 and y to 0; that pending result is lost.
  - A start coincident with rst deassertion edge is ignored only if rst is still high at that edge.
- X-handling: a and b may be X when start=0; y must not change in that case.
- Invariant: for every cycle with valid=1, y equals the wrapped sum of the operands captured one edge earlier.

Decomposition:
- Shared package design_20_pkg:
  - Default width constant `DESIGN_20_W = 8`.
  - Typedef for the W-bit data word, used by the block and the verification scoreboard.
- No sub-module required. If desired, isolate the combinational wrap-around adder as design_20_adder (W-bit in, W-bit out) so the scoreboard model can reuse the same width semantics.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start=1, a=0x12, b=0x34.
  - Expect valid=0 and y=0x00 every cycle.
  - Expect no valid in the cycle after rst release unless start is sampled post-release.
- Single transaction: a=0x05, b=0x03, start pulsed 1 cycle.
  - Expect next cycle: valid=1, y=0x08.
  - Cycle after: valid=0, y holds 0x08.
- Overflow wrap: a=0xFF, b=0x01, start pulse → valid=1, y=0x00. Then a=0xFF, b=0xFF → y=0xFE.
- Back-to-back: start high 3 consecutive cycles with (1,2), (10,20), (0x80,0x80).
  - Expect valid high 3 consecutive cycles with y = 0x03, 0x1E, 0x00, then valid=0.
- Reset mid-operation: start with a=0x40, b=0x01; assert rst asynchronously before the next edge.
  - Expect valid=0 and y=0x00 immediately.
  - After release, a fresh start with (2,2) gives y=0x04, valid=1.
- Random soak: 10+ transactions of random a and b, each a 1-cycle start followed by 2 idle cycles.
  - Check every start is followed by valid next cycle.
  - Check y equals the scoreboard's wrapped sum whenever valid=1.
  - Check valid=0 in idle cycles.
